// File: rtl/vec_write_ctrl_pkg.sv
// Shared types and constants for the vector write controller.
package vec_write_pkg;

  // Controller states: waiting for an opcode, receiving bytes, vector complete.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RECV = 2'd1,
    DONE = 2'd2
  } state_t;

  // Opcode that selects vector 0 unless the instance overrides it.
  localparam logic [7:0] OP_WR_BASE_DEFAULT = 8'h01;

  // Width of one UART byte lane.
  localparam int BYTE_W = 8;

  // Index width for n items, never less than one bit so that n == 1 still works.
  function automatic int sel_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/vec_write_ctrl_if.sv
// Bus between the command/UART side and the vector write controller.
interface vec_write_ctrl_if #(
  parameter int NUM_VEC = 2,
  parameter int VEC_LEN = 1024,
  parameter int DATA_W  = 8
);
  import vec_write_pkg::*;

  localparam int ADDR_W = $clog2(VEC_LEN);

  logic [7:0]          op;
  logic [BYTE_W-1:0]   rx_data;
  logic                rx_valid;
  logic [NUM_VEC-1:0]  wr_en;
  logic [ADDR_W-1:0]   wr_addr;
  logic [DATA_W-1:0]   wr_data;
  logic                busy;
  logic                op_finished;
  logic                aborted;
  logic [7:0]          checksum;

  // Decoder/UART side: drives opcode and bytes, observes the memory write port.
  modport master (
    output op, rx_data, rx_valid,
    input  wr_en, wr_addr, wr_data, busy, op_finished, aborted, checksum
  );

  // Controller side.
  modport slave (
    input  op, rx_data, rx_valid,
    output wr_en, wr_addr, wr_data, busy, op_finished, aborted, checksum
  );

endinterface

// File: rtl/vec_write_ctrl_byte_packer.sv
// Little-endian byte packer: collects DATA_W/8 bytes into one word and
// flags the byte that completes it. The assembled word (including the byte
// arriving this cycle) is available combinationally so the caller can
// register it on the completing cycle.
module byte_packer
  import vec_write_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              in_valid,
  input  logic [BYTE_W-1:0] in_data,
  output logic [DATA_W-1:0] word,
  output logic              word_done
);

  localparam int              LANES     = DATA_W / BYTE_W;
  localparam int              CNT_W     = sel_width(LANES);
  localparam logic [CNT_W-1:0] LAST_LANE = CNT_W'(LANES - 1);

  logic [CNT_W-1:0]  byte_cnt_reg;
  logic [DATA_W-1:0] lanes_reg;
  logic              last_lane;

  assign last_lane = (byte_cnt_reg == LAST_LANE);
  assign word_done = in_valid && last_lane;

  // The incoming byte overrides the stored lane it is destined for.
  genvar gi;
  generate
    for (gi = 0; gi < LANES; gi++) begin : g_lane
      assign word[gi*BYTE_W +: BYTE_W] =
        (in_valid && (byte_cnt_reg == CNT_W'(gi))) ? in_data
                                                   : lanes_reg[gi*BYTE_W +: BYTE_W];
    end
  endgenerate

  // Lane pointer: advances per byte, wraps after the top lane.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      byte_cnt_reg <= '0;
    end else if (clr) begin
      byte_cnt_reg <= '0;
    end else if (in_valid) begin
      byte_cnt_reg <= last_lane ? '0 : byte_cnt_reg + CNT_W'(1);
    end
  end

  // Partial word storage, emptied once a word is handed off or discarded.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lanes_reg <= '0;
    end else if (clr || word_done) begin
      lanes_reg <= '0;
    end else if (in_valid) begin
      lanes_reg <= word;
    end
  end

endmodule

// File: rtl/vec_write_ctrl.sv
// Receive-to-memory write controller: while a write-vector opcode is held,
// packs UART bytes into words and writes VEC_LEN words into the selected
// vector memory, then reports completion; withdrawing the opcode aborts.
// Optional running byte checksum is built only when VEC_WRITE_CHECKSUM_EN
// is defined; otherwise checksum is a constant zero.
module vec_write_ctrl
  import vec_write_pkg::*;
#(
  parameter int         NUM_VEC    = 2,
  parameter int         VEC_LEN    = 1024,
  parameter int         DATA_W     = 8,
  parameter logic [7:0] OP_WR_BASE = OP_WR_BASE_DEFAULT
) (
  input logic             clk,
  input logic             rst,
  vec_write_ctrl_if.slave bus
);

  localparam int               ADDR_W    = $clog2(VEC_LEN);
  localparam int               SEL_W     = sel_width(NUM_VEC);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(VEC_LEN - 1);

  state_t              state_reg, state_next;
  logic [SEL_W-1:0]    sel_reg;
  logic [ADDR_W-1:0]   word_cnt_reg;
  logic [NUM_VEC-1:0]  wr_en_reg, wr_en_next;
  logic [ADDR_W-1:0]   wr_addr_reg;
  logic [DATA_W-1:0]   wr_data_reg;
  logic                op_finished_reg;
  logic                aborted_reg;

  logic [7:0]          op_diff;
  logic                sel_valid;
  logic [SEL_W-1:0]    sel;
  logic                op_match;

  logic                start;
  logic                accept;
  logic                abort_evt;
  logic                pack_clr;
  logic                write_evt;
  logic                finish_evt;
  logic [DATA_W-1:0]   packed_word;
  logic                word_done;

  // Opcode decode: an out-of-range difference wraps high and fails the compare.
  assign op_diff   = bus.op - OP_WR_BASE;
  assign sel_valid = ({24'd0, op_diff} < 32'(NUM_VEC));
  assign sel       = op_diff[SEL_W-1:0];
  assign op_match  = sel_valid && (sel == sel_reg);

  byte_packer #(
    .DATA_W (DATA_W)
  ) u_packer (
    .clk       (clk),
    .rst       (rst),
    .clr       (pack_clr),
    .in_valid  (accept),
    .in_data   (bus.rx_data),
    .word      (packed_word),
    .word_done (word_done)
  );

  // A word completes only on an accepted byte, so an abort always suppresses it.
  assign write_evt  = word_done;
  assign finish_evt = word_done && (word_cnt_reg == LAST_ADDR);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state: leaving the latched opcode always returns to IDLE first.
  always_comb begin
    state_next = state_reg;
    unique case (state_reg)
      IDLE: if (sel_valid) state_next = RECV;
      RECV: begin
        if (!op_match)       state_next = IDLE;
        else if (finish_evt) state_next = DONE;
      end
      DONE: if (!op_match) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Per-state control strobes; bytes are only taken in RECV with the opcode intact.
  always_comb begin
    start     = 1'b0;
    accept    = 1'b0;
    abort_evt = 1'b0;
    pack_clr  = 1'b0;
    unique case (state_reg)
      IDLE: begin
        pack_clr = 1'b1;
        start    = sel_valid;
      end
      RECV: begin
        if (!op_match) begin
          abort_evt = 1'b1;
          pack_clr  = 1'b1;
        end else begin
          accept = bus.rx_valid;
        end
      end
      DONE:    pack_clr = 1'b1;
      default: pack_clr = 1'b1;
    endcase
  end

  // One-hot enable for the latched vector.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_VEC; gi++) begin : g_en
      assign wr_en_next[gi] = write_evt && (sel_reg == SEL_W'(gi));
    end
  endgenerate

  // Vector select latch and word address counter, which saturates on the last word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sel_reg      <= '0;
      word_cnt_reg <= '0;
    end else begin
      if (start) begin
        sel_reg <= sel;
      end
      if (start || abort_evt) begin
        word_cnt_reg <= '0;
      end else if (write_evt && (word_cnt_reg != LAST_ADDR)) begin
        word_cnt_reg <= word_cnt_reg + ADDR_W'(1);
      end
    end
  end

  // Registered memory write port; address and data hold between writes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_en_reg   <= '0;
      wr_addr_reg <= '0;
      wr_data_reg <= '0;
    end else begin
      wr_en_reg <= wr_en_next;
      if (write_evt) begin
        wr_addr_reg <= word_cnt_reg;
        wr_data_reg <= packed_word;
      end
    end
  end

  // Single-cycle status pulses aligned with the write they describe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_finished_reg <= 1'b0;
      aborted_reg     <= 1'b0;
    end else begin
      op_finished_reg <= finish_evt;
      aborted_reg     <= abort_evt;
    end
  end

`ifdef VEC_WRITE_CHECKSUM_EN
  logic [7:0] checksum_reg;

  // Running mod-256 byte sum, restarted on each new transfer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      checksum_reg <= '0;
    end else if (start) begin
      checksum_reg <= '0;
    end else if (accept) begin
      checksum_reg <= checksum_reg + bus.rx_data;
    end
  end

  assign bus.checksum = checksum_reg;
`else
  assign bus.checksum = 8'h00;
`endif

  assign bus.wr_en       = wr_en_reg;
  assign bus.wr_addr     = wr_addr_reg;
  assign bus.wr_data     = wr_data_reg;
  assign bus.busy        = (state_reg == RECV);
  assign bus.op_finished = op_finished_reg;
  assign bus.aborted     = aborted_reg;

endmodule

// File: doc/vec_write_ctrl.md
Name: vec_write_ctrl

Overview:
Parametrised receive-to-memory write controller for the coprocessor.
- Takes a stream of UART bytes while the command decoder holds a write-vector opcode.
- Packs the bytes into DATA_W-bit words and writes VEC_LEN words into one of NUM_VEC vector memories, using a generated address and a one-hot write enable.
- Signals completion, rejects overflow bytes, and aborts cleanly if the opcode is withdrawn mid-transfer.

Parameters:
- NUM_VEC, 2, number of vector memories; one write-enable bit each.
- VEC_LEN, 1024, words per vector; must be a power of 2, ≥ 2.
- DATA_W, 8, memory word width; must be a multiple of 8.
- OP_WR_BASE, 8'h01, opcode selecting vector 0; vector k is selected by OP_WR_BASE + k.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- op  in  8  current command opcode, level, held by the decoder.
- rx_data  in  8  received UART byte.
- rx_valid  in  1  one-cycle strobe: rx_data is valid.
- wr_en  out  NUM_VEC  one-hot write enable to the vector memories.
- wr_addr  out  $clog2(VEC_LEN)  word address.
- wr_data  out  DATA_W  packed word.
- busy  out  1  high in RECV.
- op_finished  out  1  one-cycle pulse: vector fully written.
- aborted  out  1  one-cycle pulse: opcode left during RECV.
- checksum  out  8  see Optional Feature.

Behaviour:
- Reset (async, rst=1): state IDLE; all outputs 0; word and byte counters 0; partial word cleared.
- Opcode decode: sel_valid = (op − OP_WR_BASE) < NUM_VEC, using unsigned 8-bit subtraction; sel = op − OP_WR_BASE. Any other op is a non-write opcode.
- State IDLE:
  - On sel_valid → RECV; latch sel; clear counters.
  - rx_valid is ignored in IDLE, including on the transition cycle.
- State RECV:
  - Each rx_valid byte goes into byte lane byte_cnt. Packing is little-endian: the first byte lands in bits [7:0].
  - When byte_cnt == DATA_W/8−1, the word is complete. On the next cycle wr_en[sel]=1, wr_addr=word_cnt and wr_data=the packed word, for exactly one cycle. Latency is 1 clk from the completing rx_valid.
  - byte_cnt wraps to 0; word_cnt increments.
  - On the last word (word_cnt == VEC_LEN−1), op_finished pulses in the same cycle as its wr_en; state → DONE.
  - If op changes (!sel_valid, or sel differs from the latched sel) in any RECV cycle without a word completing:
    - partial word and counters are discarded; no wr_en is issued;
    - aborted pulses 1 clk; state → IDLE.
  - If op changes in the same cycle a word completes, the abort wins: the word is not written.
- State DONE:
  - Further rx_valid bytes are dropped; no writes.
  - When op is no longer the latched opcode → IDLE. A direct switch to another write opcode goes through IDLE first, then restarts the next cycle.
- Address wrap: never occurs. word_cnt stops at VEC_LEN−1 and DONE blocks further writes.
- wr_en and wr_data are registered. wr_data holds its last value when wr_en=0.

Optional Feature:
- Macro: VEC_WRITE_CHECKSUM_EN.
- When defined:
  - checksum = mod-256 sum of every byte accepted in RECV during the current operation.
  - Cleared on the IDLE→RECV transition.
  - Valid and stable from the op_finished cycle until the next RECV entry.
  - Bytes of an aborted transfer leave checksum at its partial value.
- When undefined: checksum is tied to 8'h00 and no adder is built.

Decomposition:
- Package vec_write_pkg holds:
  - state enum typedef {IDLE, RECV, DONE};
  - OP_WR_BASE default constant;
  - byte-width constant BYTE_W = 8.
- One natural sub-module, byte_packer: shift/lane register with byte counter and word-complete strobe, parametrised by DATA_W. The top keeps the FSM, address counter and write-enable logic.

Test Plan:
- NUM_VEC=2, VEC_LEN=4, DATA_W=8, op=8'h01, bytes 11,22,33,44:
  - wr_en=2'b01 at addr 0..3 with data 11..44;
  - op_finished pulses together with the addr 3 write; busy falls.
- DATA_W=16, op=8'h02, bytes 01,02,03,04, …, 4 words:
  - wr_en=2'b10; addr0 data 16'h0201, addr1 data 16'h0403;
  - op_finished pulses after the 8th byte.
- VEC_LEN=4, op=8'h01, 2 bytes, then op=8'h00:
  - aborted pulses; no further wr_en;
  - restart with op=8'h01 and 4 bytes writes addresses 0..3 again.
- After DONE, 3 extra rx_valid bytes with op held → no wr_en. op=8'h05 (invalid) → stays IDLE and ignores bytes.
- Assert rst mid-RECV after word 1:
  - all outputs are 0 asynchronously;
  - after release with op held at a valid opcode, the transfer restarts from addr 0.
- With VEC_WRITE_CHECKSUM_EN defined, bytes FF,02,10,20 → checksum=8'h31 at op_finished. Undefined → checksum=0.
